bit_shifter: RTL and testbench

Programmable chip-select delay line with a single debounced push-button that sets the delay. The `cs`/`sdo` pair from the upstream SPI master is retimed by `len` clock cycles (0–15) before it is forwarded as `o_cs`/`miso`. Each debounced press advances `len` by one, wrapping from 15 to 0. The block sits between the SPI master pins and the target device and is used for bench timing-margin experiments.

---
 rtl/bit_shifter_pkg.sv | 19 +
 rtl/bit_shifter_debounce.sv | 63 ++++++
 rtl/bit_shifter.sv | 88 ++++++++
 tb/tb_bit_shifter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/bit_shifter_pkg.sv
// Purpose: shared widths, types and helpers for the bit_shifter delay line.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bit_shifter_pkg;

  // Delay setting width; the delay line is one tap short of 2^LEN_W because
  // setting 0 selects the undelayed input directly.
  localparam int LEN_W  = 4;
  localparam int HIST_D = (1 << LEN_W) - 1;

  typedef logic [LEN_W-1:0]  len_t;
  typedef logic [HIST_D-1:0] hist_t;

  // Advance the delay setting; wraps 15 -> 0 naturally through the width.
  function automatic len_t len_next(input len_t cur);
    return cur + len_t'(1);
  endfunction

endpackage

// File: rtl/bit_shifter_debounce.sv
// Purpose: push-button conditioning: 2-flop sync, sample divider, N-sample filter.
// Latency: btn_stable settles 2 + up to (N+1)*DIV clocks after a clean level.
// Backpressure: none; free-running, no handshake.
//
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset (already combined with POR)
//   btn_raw    - asynchronous bouncy button, active-high
//   btn_stable - filtered button level
//   o_clk      - heartbeat, toggles on every sample tick
module bit_shifter_debounce
  import bit_shifter_pkg::*;
#(
  parameter int DIV = 50_000,
  parameter int N   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_stable,
  output logic o_clk
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [1:0]    sync_q;
  logic [CW-1:0] div_cnt;
  logic          sample_en;
  logic [N-1:0]  smp_hist;

  assign sample_en = (div_cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      div_cnt  <= '0;
      o_clk    <= 1'b0;
      smp_hist <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      if (sample_en) begin
        div_cnt  <= '0;
        o_clk    <= ~o_clk;
        smp_hist <= {smp_hist[N-2:0], sync_q[1]};
      end else begin
        div_cnt <= div_cnt + CW'(1);
      end
    end
  end

  // Level only moves on a unanimous history; mixed history holds the old level,
  // so any bounce or gap shorter than N samples is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_stable <= 1'b0;
    end else if (&smp_hist) begin
      btn_stable <= 1'b1;
    end else if (~|smp_hist) begin
      btn_stable <= 1'b0;
    end
  end

endmodule

// File: rtl/bit_shifter.sv
// Purpose: programmable 0..15-cycle delay of cs/sdo, delay stepped by a debounced button.
// Latency: len cycles on o_cs/miso (len 0 is purely combinational).
// Backpressure: none; streams every clock, no handshake.
//
// Ports:
//   clk, rst      - system clock, synchronous active-high reset (ORed with POR)
//   cs, sdo       - upstream SPI chip select and serial data
//   btn_raw       - bouncy push-button, each press advances the delay by one
//   o_cs, miso    - delayed cs / sdo
//   o_clk         - debounce heartbeat
//   o_cs_en       - high whenever a non-zero delay is selected
module bit_shifter
  import bit_shifter_pkg::*;
#(
  parameter int DIV = 50_000,
  parameter int N   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic cs,
  input  logic sdo,
  input  logic btn_raw,
  output logic miso,
  output logic o_cs,
  output logic o_clk,
  output logic o_cs_en
);

  // Power-on reset: relies on the flops powering up at 0, which holds the
  // block in reset for the first two clocks until ones have shifted through.
  logic [1:0] por_sr;
  logic       rst_i;

  always_ff @(posedge clk) begin
    por_sr <= {por_sr[0], 1'b1};
  end

  assign rst_i = rst | ~por_sr[1];

  logic btn_stable;
  logic btn_stable_q;
  len_t len;
  hist_t cs_hist;
  hist_t sdo_hist;

  bit_shifter_debounce #(
    .DIV (DIV),
    .N   (N)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst_i),
    .btn_raw    (btn_raw),
    .btn_stable (btn_stable),
    .o_clk      (o_clk)
  );

  // Only the rising edge of the filtered level counts, so a held button
  // produces exactly one step. The delay lines are never flushed when len
  // changes; the new tap takes effect on the following cycle.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      btn_stable_q <= 1'b0;
      len          <= '0;
      cs_hist      <= '0;
      sdo_hist     <= '0;
    end else begin
      btn_stable_q <= btn_stable;
      if (btn_stable && !btn_stable_q) begin
        len <= len_next(len);
      end
      cs_hist  <= {cs_hist[HIST_D-2:0], cs};
      sdo_hist <= {sdo_hist[HIST_D-2:0], sdo};
    end
  end

  // Prepending the live input as tap 0 makes len==0 the combinational bypass
  // and len==k select hist[k-1] with a single index.
  logic [HIST_D:0] cs_tap;
  logic [HIST_D:0] sdo_tap;

  assign cs_tap  = {cs_hist, cs};
  assign sdo_tap = {sdo_hist, sdo};

  assign o_cs    = cs_tap[len];
  assign miso    = sdo_tap[len];
  assign o_cs_en = (len != '0);

endmodule

// File: tb/tb_bit_shifter.sv
module tb_bit_shifter;

  localparam int DIV = 4;
  localparam int N   = 4;

  logic clk = 1'b0;
  logic rst;
  logic cs;
  logic sdo;
  logic btn_raw;
  logic miso;
  logic o_cs;
  logic o_clk;
  logic o_cs_en;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] model_len = 4'd0;

  always #5 clk = ~clk;

  bit_shifter #(
    .DIV (DIV),
    .N   (N)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cs      (cs),
    .sdo     (sdo),
    .btn_raw (btn_raw),
    .miso    (miso),
    .o_cs    (o_cs),
    .o_clk   (o_clk),
    .o_cs_en (o_cs_en)
  );

  typedef struct {
    logic [3:0]  k;
    logic [11:0] cs_in;
    logic [11:0] sdo_in;
    logic [11:0] exp_cs;
    logic [11:0] exp_miso;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press();
    btn_raw = 1'b1;
    repeat ((N + 1) * DIV) tick();
    btn_raw = 1'b0;
    repeat ((N + 1) * DIV) tick();
    repeat (DIV) tick();
    model_len = model_len + 4'd1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic prev;
    int   cnt;

    // Stream bit i is applied during cycle i; output at cycle i is input at i-k.
    vecs[0] = '{k: 4'd0, cs_in: 12'b0000_0010_0110, sdo_in: 12'b1010_0101_1100,
                exp_cs: 12'b0000_0010_0110, exp_miso: 12'b1010_0101_1100};
    vecs[1] = '{k: 4'd1, cs_in: 12'b0000_0000_0010, sdo_in: 12'b0000_0011_0101,
                exp_cs: 12'b0000_0000_0100, exp_miso: 12'b0000_0110_1010};
    vecs[2] = '{k: 4'd5, cs_in: 12'b0000_0000_0001, sdo_in: 12'b0000_0000_1101,
                exp_cs: 12'b0000_0010_0000, exp_miso: 12'b0001_1010_0000};
    vecs[3] = '{k: 4'd7, cs_in: 12'b0000_0001_1110, sdo_in: 12'b0000_0000_0101,
                exp_cs: 12'b1111_0000_0000, exp_miso: 12'b0010_1000_0000};

    rst = 1'b1; cs = 1'b0; sdo = 1'b0; btn_raw = 1'b0;
    repeat (4) tick();

    // Reset state and combinational bypass while held in reset.
    check("rst_len", dut.len, 0);
    check("rst_cs_en", o_cs_en, 0);
    check("rst_oclk", o_clk, 0);
    cs = 1'b1; #1; check("rst_bypass_cs_hi", o_cs, 1);
    cs = 1'b0; #1; check("rst_bypass_cs_lo", o_cs, 0);
    sdo = 1'b1; #1; check("rst_bypass_sdo_hi", miso, 1);
    sdo = 1'b0; #1; check("rst_bypass_sdo_lo", miso, 0);
    rst = 1'b0;
    tick();

    // Heartbeat half-period is DIV clocks.
    prev = o_clk; cnt = 0;
    while (o_clk == prev && cnt < 4 * DIV) begin tick(); cnt++; end
    check("oclk_first_toggle", (cnt < 4 * DIV) ? 1 : 0, 1);
    prev = o_clk; cnt = 0;
    while (o_clk == prev && cnt < 4 * DIV) begin tick(); cnt++; end
    check("oclk_half_period", cnt, DIV);

    // Table: step len with clean presses, then stream and compare every cycle.
    for (int v = 0; v < 4; v++) begin
      while (model_len != vecs[v].k) press();
      check($sformatf("vec%0d_len", v), dut.len, model_len);
      check($sformatf("vec%0d_cs_en", v), o_cs_en, (model_len != 0) ? 1 : 0);
      cs = 1'b0; sdo = 1'b0;
      repeat (16) tick();
      for (int i = 0; i < 12; i++) begin
        cs  = vecs[v].cs_in[i];
        sdo = vecs[v].sdo_in[i];
        #1;
        check($sformatf("vec%0d_cyc%0d_cs", v, i), o_cs, vecs[v].exp_cs[i]);
        check($sformatf("vec%0d_cyc%0d_miso", v, i), miso, vecs[v].exp_miso[i]);
        tick();
      end
    end

    // Mid-operation reset at len 7 with cs toggling.
    for (int i = 0; i < 10; i++) begin
      cs = ~cs; sdo = cs;
      tick();
    end
    rst = 1'b1;
    tick();
    check("midrst_len", dut.len, 0);
    check("midrst_cs_hist", dut.cs_hist, 0);
    check("midrst_sdo_hist", dut.sdo_hist, 0);
    check("midrst_cs_en", o_cs_en, 0);
    rst = 1'b0;
    model_len = 4'd0;
    cs = 1'b1; #1; check("midrst_bypass_hi", o_cs, 1);
    cs = 1'b0; #1; check("midrst_bypass_lo", o_cs, 0);
    tick();

    // Bouncy single press: 8 high / 5 low / 6 high, then a clean press.
    btn_raw = 1'b1; repeat (8) tick();
    btn_raw = 1'b0; repeat (5) tick();
    btn_raw = 1'b1; repeat (6) tick();
    press();
    check("bounce_press_len", dut.len, 1);
    check("bounce_press_cs_en", o_cs_en, 1);

    // Ten short glitches never reach N unanimous samples.
    for (int g = 0; g < 10; g++) begin
      btn_raw = 1'b1; repeat (6) tick();
      btn_raw = 1'b0; repeat (10) tick();
    end
    repeat ((N + 1) * DIV) tick();
    check("glitch_len", dut.len, model_len);

    // Wrap: 16 presses from 0 come back to 0 and the bypass returns.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    model_len = 4'd0;
    for (int p = 0; p < 16; p++) begin
      press();
      check($sformatf("wrap_press%0d_len", p), dut.len, model_len);
    end
    check("wrap_final_len", dut.len, 0);
    check("wrap_cs_en", o_cs_en, 0);
    cs = 1'b1; #1; check("wrap_bypass_hi", o_cs, 1);
    cs = 1'b0; #1; check("wrap_bypass_lo", o_cs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
